// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions.
//   ADDR_W, DATA_W : default PC and instruction widths
//   NOP_INSTR      : bubble instruction (addi x0,x0,0)
//   INSTR_BYTES    : PC increment per fetched instruction
//   ifid_t         : IF/ID pipeline register contents {pc, pc4, instr, valid}
package fetch_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic [DATA_W-1:0] instr;
    logic              valid;
  } ifid_t;

  // Bubble contents: zero PC fields, NOP, not valid.
  function automatic ifid_t ifid_bubble(input logic [DATA_W-1:0] nop);
    ifid_t b;
    b.pc    = '0;
    b.pc4   = '0;
    b.instr = nop;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-ROM bus between the fetch stage and an asynchronous ROM.
//   imem_addr : byte address driven by fetch (master)
//   imem_data : read data returned combinationally by the ROM (slave)
interface fetch_stage_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0]    imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold / bubble / load control.
//   clk, rst_n : clock and asynchronous active-low reset (resets to bubble)
//   hold       : keep current contents
//   bubble     : replace contents with a bubble (wins over hold)
//   load_data  : contents captured when neither hold nor bubble
//   ifid       : registered contents
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] BUBBLE_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold,
  input  logic  bubble,
  input  ifid_t load_data,
  output ifid_t ifid
);

  ifid_t ifid_d, ifid_q;

  always_comb begin
    ifid_d = ifid_q;
    if (bubble) begin
      ifid_d = ifid_bubble(BUBBLE_INSTR);
    end else if (!hold) begin
      ifid_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= ifid_bubble(BUBBLE_INSTR);
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the asynchronous instruction ROM address
// and captures the returned word into the IF/ID register. Handles stall, flush and
// branch/jump redirect (redirect > flush > stall > normal fetch).
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem              : ROM bus (imem_addr = pc, imem_data same cycle)
//   stall_i           : hold pc and IF/ID
//   flush_i           : bubble IF/ID; pc still advances unless stalled
//   redirect_valid_i  : load pc with redirect_pc_i and bubble IF/ID
//   redirect_pc_i     : redirect target byte address
//   if_id_*_o         : IF/ID contents (pc, pc+4, instruction, valid)
//   misalign_o        : sticky misaligned-redirect flag
// Optional build macro FETCH_ALIGN_CHECK_EN: clears redirect_pc_i[1:0] on load and raises
// misalign_o when they were nonzero. Without it the target is loaded verbatim and
// misalign_o is tied low.
module fetch_stage #(
  parameter int unsigned               ADDRESS_WIDTH = 8,
  parameter int unsigned               DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fetch_stage_if.master            imem,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     redirect_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc_o,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc4_o,
  output logic [DATA_WIDTH-1:0]    if_id_instr_o,
  output logic                     if_id_valid_o,
  output logic                     misalign_o
);

  import fetch_pkg::ifid_t;
  import fetch_pkg::INSTR_BYTES;

  logic [ADDRESS_WIDTH-1:0] pc_d, pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  ifid_t                    load_data;
  ifid_t                    ifid;
  logic                     ifid_bubble_en;
  logic                     ifid_hold;

  // Wraps modulo 2**ADDRESS_WIDTH.
  assign pc_plus4 = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_d, misalign_q;

  assign redirect_target = {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
  assign misalign_d      = misalign_q | (redirect_valid_i & (|redirect_pc_i[1:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign redirect_target = redirect_pc_i;
  assign misalign_o      = 1'b0;
`endif

  // Flush with stall still holds pc; redirect overrides both.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid_i) begin
      pc_d = redirect_target;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem.imem_addr = pc_q;

  assign ifid_bubble_en = redirect_valid_i | flush_i;
  assign ifid_hold      = stall_i;

  always_comb begin
    load_data.pc    = pc_q;
    load_data.pc4   = pc_plus4;
    load_data.instr = imem.imem_data;
    load_data.valid = 1'b1;
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (ifid_hold),
    .bubble   (ifid_bubble_en),
    .load_data(load_data),
    .ifid     (ifid)
  );

  assign if_id_pc_o    = ifid.pc;
  assign if_id_pc4_o   = ifid.pc4;
  assign if_id_instr_o = ifid.instr;
  assign if_id_valid_o = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [7:0]  redirect_pc_i = 8'h00;
  logic [7:0]  if_id_pc_o;
  logic [7:0]  if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        misalign_o;

  logic [31:0] rom [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) imem_bus ();

  assign imem_bus.imem_data = rom[imem_bus.imem_addr[7:2]];

  fetch_stage #(
    .ADDRESS_WIDTH(8),
    .DATA_WIDTH   (32),
    .RESET_PC     (8'h00),
    .NOP_INSTR    (NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem            (imem_bus.master),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .if_id_pc_o      (if_id_pc_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_valid_o   (if_id_valid_o),
    .misalign_o      (misalign_o)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        rv;
    logic [7:0]  rpc;
    logic [7:0]  e_pc;
    logic [7:0]  e_pc4;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [7:0]  e_addr;
    logic        e_mis;
  } vec_t;

  vec_t vecs [17];

  // {pc, pc4, instr, valid, imem_addr, misalign}
  function automatic logic [63:0] pack(input logic [7:0] pc, input logic [7:0] pc4,
                                       input logic [31:0] instr, input logic valid,
                                       input logic [7:0] addr, input logic mis);
    return {6'b0, pc, pc4, instr, valid, addr, mis};
  endfunction

  function automatic logic [63:0] observe();
    return pack(if_id_pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o,
                imem_bus.imem_addr, misalign_o);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (pc,pc4,instr,valid,addr,mis)", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic rv, input logic [7:0] rpc,
                              input logic [7:0] pc, input logic [7:0] pc4,
                              input logic [31:0] instr, input logic v,
                              input logic [7:0] addr, input logic mis);
    vec_t r;
    r.stall = s; r.flush = f; r.rv = rv; r.rpc = rpc;
    r.e_pc = pc; r.e_pc4 = pc4; r.e_instr = instr; r.e_valid = v;
    r.e_addr = addr; r.e_mis = mis;
    return r;
  endfunction

  // Reference model state
  logic [7:0]  m_pc;
  logic [7:0]  m_ipc, m_ipc4;
  logic [31:0] m_instr;
  logic        m_valid, m_mis;

  task automatic model_reset();
    m_pc = 8'h00; m_ipc = 8'h00; m_ipc4 = 8'h00; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic f, input logic rv, input logic [7:0] rpc);
    if (rv) begin
      m_pc = ALIGN ? (rpc & 8'hFC) : rpc;
      if (ALIGN && (rpc % 4 != 0)) m_mis = 1'b1;
      m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 1'b0;
    end else if (f) begin
      m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 1'b0;
      if (!s) m_pc = 8'((int'(m_pc) + 4) % 256);
    end else if (!s) begin
      m_ipc   = m_pc;
      m_ipc4  = 8'((int'(m_pc) + 4) % 256);
      m_instr = rom[int'(m_pc) / 4];
      m_valid = 1'b1;
      m_pc    = m_ipc4;
    end
  endtask

  initial begin
    logic s, f, rv;
    logic [7:0] rpc;

    for (int i = 0; i < 64; i++) rom[i] = (i < 4) ? 32'(17 * (i + 1)) : (32'hA000_0000 | i);

    vecs[0]  = mk(0, 0, 0, 8'h00, 8'h00, 8'h04, 32'h11, 1, 8'h04, 0);
    vecs[1]  = mk(0, 0, 0, 8'h00, 8'h04, 8'h08, 32'h22, 1, 8'h08, 0);
    vecs[2]  = mk(1, 0, 0, 8'h00, 8'h04, 8'h08, 32'h22, 1, 8'h08, 0);
    vecs[3]  = mk(1, 0, 0, 8'h00, 8'h04, 8'h08, 32'h22, 1, 8'h08, 0);
    vecs[4]  = mk(1, 0, 0, 8'h00, 8'h04, 8'h08, 32'h22, 1, 8'h08, 0);
    vecs[5]  = mk(0, 0, 0, 8'h00, 8'h08, 8'h0C, 32'h33, 1, 8'h0C, 0);
    vecs[6]  = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, NOP, 0, 8'h10, 0);
    vecs[7]  = mk(0, 0, 0, 8'h00, 8'h10, 8'h14, 32'hA000_0004, 1, 8'h14, 0);
    vecs[8]  = mk(1, 0, 1, 8'h40, 8'h00, 8'h00, NOP, 0, 8'h40, 0);
    vecs[9]  = mk(0, 0, 0, 8'h00, 8'h40, 8'h44, 32'hA000_0010, 1, 8'h44, 0);
    vecs[10] = mk(0, 0, 1, 8'hFC, 8'h00, 8'h00, NOP, 0, 8'hFC, 0);
    vecs[11] = mk(0, 0, 0, 8'h00, 8'hFC, 8'h00, 32'hA000_003F, 1, 8'h00, 0);
    vecs[12] = mk(1, 1, 0, 8'h00, 8'h00, 8'h00, NOP, 0, 8'h00, 0);
    vecs[13] = mk(0, 0, 0, 8'h00, 8'h00, 8'h04, 32'h11, 1, 8'h04, 0);
    vecs[14] = mk(0, 0, 1, 8'h42, 8'h00, 8'h00, NOP, 0, ALIGN ? 8'h40 : 8'h42, ALIGN);
    vecs[15] = mk(0, 0, 0, 8'h00, ALIGN ? 8'h40 : 8'h42, ALIGN ? 8'h44 : 8'h46,
                  32'hA000_0010, 1, ALIGN ? 8'h44 : 8'h46, ALIGN);
    vecs[16] = mk(0, 0, 1, 8'h08, 8'h00, 8'h00, NOP, 0, 8'h08, ALIGN);

    // Reset values
    #12;
    chk("reset", observe(), pack(8'h00, 8'h00, NOP, 1'b0, 8'h00, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      stall_i = vecs[i].stall; flush_i = vecs[i].flush;
      redirect_valid_i = vecs[i].rv; redirect_pc_i = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), observe(),
          pack(vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_instr, vecs[i].e_valid,
               vecs[i].e_addr, vecs[i].e_mis));
    end

    // Reset asserted mid-stall: outputs return to reset values without a clock edge
    stall_i = 1'b1; flush_i = 1'b0; redirect_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", observe(), pack(8'h00, 8'h00, NOP, 1'b0, 8'h00, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    stall_i = 1'b0;
    @(posedge clk); #1;
    chk("restart", observe(), pack(8'h00, 8'h04, 32'h11, 1'b1, 8'h04, 1'b0));

    // Randomized run against the reference model
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = 8'($urandom_range(0, 255));
      stall_i = s; flush_i = f; redirect_valid_i = rv; redirect_pc_i = rpc;
      model_step(s, f, rv, rpc);
      @(posedge clk); #1;
      chk($sformatf("rand%0d", n), observe(),
          pack(m_ipc, m_ipc4, m_instr, m_valid, m_pc, m_mis));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
